bcd_to_bin_seq: RTL

BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

---
 rtl/bcd_to_bin_seq_pkg.sv | 30 +++
 rtl/bcd_digit_adj.sv | 19 +
 rtl/bcd_to_bin_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared abacus package for the sequential BCD-to-binary converter:
// default sizes, FSM state encoding and a width helper.
package bcd_to_bin_seq_pkg;

    localparam int NDIG_DEF  = 5;
    localparam int OUT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Smallest w with 2^w >= 10^ndig, i.e. ceil(log2(10^ndig)).
    function automatic int bin_width(input int ndig);
        longint unsigned limit;
        int              w;
        limit = 64'd1;
        for (int i = 0; i < ndig; i++) begin
            limit = limit * 64'd10;
        end
        w = 0;
        while ((64'd1 << w) < limit) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction cell for reverse double-dabble:
// after a right shift, a digit that reads 8 or more received a
// carried-in weight of 8 that is really worth 5, so subtract 3.
module bcd_digit_adj (
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    // Subtract 3 from digits of 8 or more, pass others through.
    always_comb begin
        d_out = d_in;
        if (d_in >= 4'd8) begin
            d_out = d_in - 4'd3;
        end else begin
            d_out = d_in;
        end
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter.
// A validated BCD word is shifted right one bit per cycle into a binary
// accumulator (reverse double-dabble). The binary result saturates to
// all ones with ovf set when it does not fit in OUT_W bits; an input
// with any digit above 9 finishes early with err set and result 0.
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int NDIG  = NDIG_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [4*NDIG-1:0] bcd_in,
    output logic              busy,
    output logic              done,
    output logic [OUT_W-1:0]  result,
    output logic              ovf,
    output logic              err
);

    // Digit-word width; the binary half of the shift pair has the same
    // width so every shifted-out bit is kept. After 4*NDIG shifts the
    // value lives in the low BIN_W bits and the bits above are zero.
    localparam int DW    = 4 * NDIG;
    localparam int BIN_W = bin_width(NDIG);
    localparam int CNT_W = (DW > 1) ? $clog2(DW) : 1;
    localparam int EXT_W = BIN_W + OUT_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DW - 1);

    state_e              state_q,  state_d;
    logic [DW-1:0]       bcd_q,    bcd_d;
    logic [DW-1:0]       bin_q,    bin_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic [OUT_W-1:0]    result_q, result_d;
    logic                ovf_q,    ovf_d;
    logic                err_q,    err_d;

    logic [2*DW-1:0]     pair_sh_s;
    logic [DW-1:0]       bcd_sh_s;
    logic [DW-1:0]       bcd_adj_s;
    logic [DW-1:0]       bin_sh_s;
    logic [BIN_W-1:0]    bin_val_s;
    logic [EXT_W-1:0]    bin_ext_s;
    logic                ovf_s;
    logic [OUT_W-1:0]    sat_s;
    logic                bad_digit_s;

    // One right shift of the {BCD, binary} pair.
    assign pair_sh_s = {bcd_q, bin_q} >> 1;
    assign bcd_sh_s  = pair_sh_s[2*DW-1:DW];
    assign bin_sh_s  = pair_sh_s[DW-1:0];

    // Per-digit correction applied to the freshly shifted BCD half.
    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_in  (bcd_sh_s[4*g +: 4]),
            .d_out (bcd_adj_s[4*g +: 4])
        );
    end

    // Final binary value and its saturated OUT_W view, valid on the last shift.
    always_comb begin
        bin_val_s = bin_sh_s[BIN_W-1:0];
        bin_ext_s = EXT_W'(bin_val_s);
        ovf_s     = |bin_ext_s[EXT_W-1:OUT_W];
        sat_s     = bin_ext_s[OUT_W-1:0];
        if (ovf_s) begin
            sat_s = {OUT_W{1'b1}};
        end else begin
            sat_s = bin_ext_s[OUT_W-1:0];
        end
    end

    // Flag any captured digit that is not a decimal digit.
    always_comb begin
        bad_digit_s = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            bad_digit_s = bad_digit_s | (bcd_q[4*i +: 4] > 4'd9);
        end
    end

    // Next-state and next-datapath logic for the conversion FSM.
    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        ovf_d    = ovf_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bcd_d   = bcd_in;
                    busy_d  = 1'b1;
                    state_d = CHECK;
                end else begin
                    busy_d  = 1'b0;
                end
            end

            CHECK: begin
                if (bad_digit_s) begin
                    result_d = {OUT_W{1'b0}};
                    ovf_d    = 1'b0;
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = DONE;
                end else begin
                    bin_d    = {DW{1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
                    state_d  = SHIFT;
                end
            end

            SHIFT: begin
                bcd_d = bcd_adj_s;
                bin_d = bin_sh_s;
                if (cnt_q == LAST_CNT) begin
                    // Last shift: publish the result as DONE is entered.
                    cnt_d    = {CNT_W{1'b0}};
                    result_d = sat_s;
                    ovf_d    = ovf_s;
                    err_d    = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = DONE;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // All FSM and datapath registers, with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            bcd_q    <= {DW{1'b0}};
            bin_q    <= {DW{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= {OUT_W{1'b0}};
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcd_q    <= bcd_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign ovf    = ovf_q;
    assign err    = err_q;

endmodule
